// File: rtl/ex_muldiv_ctrl_pkg.sv
// Shared CPU definitions for the multiply/divide unit: op encodings, FSM states and
// sign helpers. MADD/MADDU/MSUB/MSUBU encodings are decoded only under MULDIV_MADD_EN.
package ex_muldiv_ctrl_pkg;

  localparam int DIV_CYCLES = 32;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL     = 2'd1,
    DIV     = 2'd2,
    DIV_FIX = 2'd3
  } muldiv_state_t;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_div_iter.sv
// Iterative restoring unsigned divider, one quotient bit per cycle, MSB first.
// done marks the cycle performing the final step; results are stable from the next cycle.
module ex_div_iter
  import ex_muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  localparam int CNT_W = $clog2(DIV_CYCLES) + 1;

  logic [CNT_W-1:0] count_r;
  logic             active_r;
  logic [31:0]      quo_r;
  logic [31:0]      rem_r;
  logic [31:0]      div_r;
  logic [32:0]      rem_shift_s;
  logic [32:0]      trial_s;
  logic             ge_s;
  logic             last_s;

  // Trial subtraction of the divisor from the partial remainder shifted by one bit.
  always_comb begin
    rem_shift_s = {rem_r, quo_r[31]};
    trial_s     = rem_shift_s - {1'b0, div_r};
    ge_s        = (rem_shift_s >= {1'b0, div_r});
    last_s      = active_r && (count_r == CNT_W'(DIV_CYCLES - 1));
  end

  // Iteration registers: quo_r starts as the dividend and fills with quotient bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r  <= '0;
      active_r <= 1'b0;
      quo_r    <= 32'd0;
      rem_r    <= 32'd0;
      div_r    <= 32'd0;
    end else if (abort) begin
      count_r  <= '0;
      active_r <= 1'b0;
    end else if (start) begin
      count_r  <= '0;
      active_r <= 1'b1;
      quo_r    <= dividend;
      rem_r    <= 32'd0;
      div_r    <= divisor;
    end else if (active_r) begin
      quo_r    <= {quo_r[30:0], ge_s};
      rem_r    <= ge_s ? trial_s[31:0] : rem_shift_s[31:0];
      count_r  <= last_s ? '0 : count_r + CNT_W'(1);
      active_r <= !last_s;
    end
  end

  assign quotient  = quo_r;
  assign remainder = rem_r;
  assign done      = last_s;

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// HI/LO multiply/divide controller: single-cycle MUL, 32+1 cycle signed/unsigned DIV,
// MTHI/MTLO writes. Multiply-accumulate ops are built only when MULDIV_MADD_EN is defined.
module ex_muldiv_ctrl
  import ex_muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic [63:0] hilo
);

  muldiv_state_t state_r;
  muldiv_state_t state_next_s;
  muldiv_op_t    op_s;
  muldiv_op_t    op_r;
  logic [31:0]   a_r;
  logic [31:0]   b_r;
  logic          q_neg_r;
  logic          r_neg_r;
  logic          busy_r;
  logic [63:0]   hilo_r;
  logic          op_known_s;
  logic          accept_s;
  logic          is_div_s;
  logic          sdiv_s;
  logic          msigned_s;
  logic [63:0]   a_ext_s;
  logic [63:0]   b_ext_s;
  logic [63:0]   prod_s;
  logic          hilo_we_s;
  logic [63:0]   hilo_next_s;
  logic [31:0]   div_quo_s;
  logic [31:0]   div_rem_s;
  logic          div_done_s;

  assign op_s = muldiv_op_t'(op);

  // Decode which encodings this build implements; everything else behaves as NONE.
  always_comb begin
    op_known_s = 1'b0;
    case (op_s)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO: op_known_s = 1'b1;
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU:                 op_known_s = 1'b1;
`endif
      default:                                              op_known_s = 1'b0;
    endcase
  end

  // Acceptance and divider operand conditioning.
  always_comb begin
    accept_s = (state_r == IDLE) && op_valid && !flush && op_known_s;
    is_div_s = (op_s == OP_DIV) || (op_s == OP_DIVU);
    sdiv_s   = (op_s == OP_DIV);
  end

  // Low 64 bits of the product of 64-bit extended operands cover both signednesses.
  always_comb begin
    msigned_s = (op_r == OP_MULT) || (op_r == OP_MADD) || (op_r == OP_MSUB);
    a_ext_s   = {{32{msigned_s & a_r[31]}}, a_r};
    b_ext_s   = {{32{msigned_s & b_r[31]}}, b_r};
    prod_s    = a_ext_s * b_ext_s;
  end

  ex_div_iter u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (accept_s && is_div_s),
    .abort     (flush),
    .dividend  (sdiv_s ? abs32(src_a) : src_a),
    .divisor   (sdiv_s ? abs32(src_b) : src_b),
    .quotient  (div_quo_s),
    .remainder (div_rem_s),
    .done      (div_done_s)
  );

  // Next-state and HI/LO write selection; flush overrides everything.
  always_comb begin
    state_next_s = state_r;
    hilo_we_s    = 1'b0;
    hilo_next_s  = hilo_r;
    if (flush) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            case (op_s)
              OP_MTHI: begin
                hilo_we_s   = 1'b1;
                hilo_next_s = {src_a, hilo_r[31:0]};
              end
              OP_MTLO: begin
                hilo_we_s   = 1'b1;
                hilo_next_s = {hilo_r[63:32], src_a};
              end
              OP_DIV, OP_DIVU: state_next_s = DIV;
              default:         state_next_s = MUL;
            endcase
          end else begin
            state_next_s = IDLE;
          end
        end
        MUL: begin
          state_next_s = IDLE;
          hilo_we_s    = 1'b1;
          case (op_r)
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MADDU: hilo_next_s = hilo_r + prod_s;
            OP_MSUB, OP_MSUBU: hilo_next_s = hilo_r - prod_s;
`endif
            default:           hilo_next_s = prod_s;
          endcase
        end
        DIV: begin
          if (div_done_s) begin
            state_next_s = DIV_FIX;
          end else begin
            state_next_s = DIV;
          end
        end
        DIV_FIX: begin
          state_next_s = IDLE;
          hilo_we_s    = 1'b1;
          hilo_next_s  = {neg_if(div_rem_s, r_neg_r), neg_if(div_quo_s, q_neg_r)};
        end
        default: state_next_s = IDLE;
      endcase
    end
  end

  // State register; busy is registered alongside so it equals (state != IDLE).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != IDLE);
    end
  end

  // Architectural HI/LO and operands captured at acceptance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hilo_r  <= 64'd0;
      op_r    <= OP_NONE;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      q_neg_r <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      if (hilo_we_s) begin
        hilo_r <= hilo_next_s;
      end
      if (accept_s) begin
        op_r    <= op_s;
        a_r     <= src_a;
        b_r     <= src_b;
        q_neg_r <= sdiv_s & (src_a[31] ^ src_b[31]);
        r_neg_r <= sdiv_s & src_a[31];
      end
    end
  end

  assign busy = busy_r;
  assign hilo = hilo_r;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl: an arithmetic model of HI/LO and busy latency
// is compared every cycle, plus literal expectations. Honours MULDIV_MADD_EN.
module tb_ex_muldiv_ctrl;

  localparam logic [3:0] C_NONE  = 4'd0;
  localparam logic [3:0] C_MULT  = 4'd1;
  localparam logic [3:0] C_MULTU = 4'd2;
  localparam logic [3:0] C_DIV   = 4'd3;
  localparam logic [3:0] C_DIVU  = 4'd4;
  localparam logic [3:0] C_MTHI  = 4'd5;
  localparam logic [3:0] C_MTLO  = 4'd6;
  localparam logic [3:0] C_MADD  = 4'd7;
  localparam logic [3:0] C_MADDU = 4'd8;
  localparam logic [3:0] C_MSUB  = 4'd9;
  localparam logic [3:0] C_MSUBU = 4'd10;
`ifdef MULDIV_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic [63:0] hilo;

  int n_cmp = 0;
  int n_fail = 0;
  int busy_cycles = 0;

  logic [63:0] m_hilo = 64'd0;
  logic [63:0] m_pend = 64'd0;
  int          m_cnt = 0;

  ex_muldiv_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .busy     (busy),
    .hilo     (hilo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] p;
    if (sgn) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    p = sa * sb;
    return p;
  endfunction

  function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] q;
    logic signed [63:0] r;
    if (b == 32'd0) begin
      return {a, ((sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF)};
    end
    if (sgn) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Architectural effect of one rising edge given the inputs presented before it.
  task automatic model_edge();
    if (!rst) begin
      m_hilo = 64'd0;
      m_cnt  = 0;
    end else if (flush) begin
      m_cnt = 0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) m_hilo = m_pend;
    end else if (op_valid) begin
      case (op)
        C_MTHI:  m_hilo[63:32] = src_a;
        C_MTLO:  m_hilo[31:0]  = src_a;
        C_MULT:  begin m_cnt = 1;  m_pend = mul_model(src_a, src_b, 1'b1); end
        C_MULTU: begin m_cnt = 1;  m_pend = mul_model(src_a, src_b, 1'b0); end
        C_DIV:   begin m_cnt = 33; m_pend = div_model(src_a, src_b, 1'b1); end
        C_DIVU:  begin m_cnt = 33; m_pend = div_model(src_a, src_b, 1'b0); end
        C_MADD:  if (MADD_EN) begin m_cnt = 1; m_pend = m_hilo + mul_model(src_a, src_b, 1'b1); end
        C_MADDU: if (MADD_EN) begin m_cnt = 1; m_pend = m_hilo + mul_model(src_a, src_b, 1'b0); end
        C_MSUB:  if (MADD_EN) begin m_cnt = 1; m_pend = m_hilo - mul_model(src_a, src_b, 1'b1); end
        C_MSUBU: if (MADD_EN) begin m_cnt = 1; m_pend = m_hilo - mul_model(src_a, src_b, 1'b0); end
        default: ;
      endcase
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: model the edge, then compare DUT outputs on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("busy_model", 64'(busy), 64'(m_cnt > 0));
    check("hilo_model", hilo, m_hilo);
    if (busy === 1'b1) busy_cycles++;
  endtask

  task automatic offer(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
    step();
    op_valid = 1'b0;
    op       = C_NONE;
  endtask

  task automatic wait_idle(input int max_cyc);
    int k = 0;
    while (busy !== 1'b0 && k < max_cyc) begin
      step();
      k++;
    end
    check("idle_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    check("reset_hilo", hilo, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);

    // MULT -2 * 3
    busy_cycles = 0;
    offer(C_MULT, 32'hFFFF_FFFE, 32'd3);
    check("mult_busy_n1", 64'(busy), 64'd1);
    step();
    check("mult_hilo", hilo, 64'hFFFF_FFFF_FFFF_FFFA);
    check("mult_busy_cycles", 64'(busy_cycles), 64'd1);

    offer(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    check("multu_hilo", hilo, 64'hFFFF_FFFE_0000_0001);

    // DIV -7 / 2 with offers made while busy
    busy_cycles = 0;
    offer(C_DIV, 32'hFFFF_FFF9, 32'd2);
    for (int i = 0; i < 4; i++) step();
    op_valid = 1'b1; op = C_MTLO; src_a = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) step();
    op_valid = 1'b0; op = C_NONE;
    wait_idle(40);
    check("div_busy_cycles", 64'(busy_cycles), 64'd33);
    check("div_hilo", hilo, 64'hFFFF_FFFF_FFFF_FFFD);

    offer(C_DIVU, 32'd7, 32'd0);
    wait_idle(40);
    check("divu_zero", hilo, 64'h0000_0007_FFFF_FFFF);

    offer(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(40);
    check("div_ovf", hilo, 64'h0000_0000_8000_0000);

    offer(C_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_idle(40);
    check("div_pos_neg", hilo, 64'h0000_0001_FFFF_FFFD);

    offer(C_DIV, 32'hFFFF_FFFB, 32'd0);
    wait_idle(40);
    check("div_neg_zero", hilo, 64'hFFFF_FFFB_0000_0001);

    offer(C_DIVU, 32'hFFFF_FFFF, 32'd10);
    wait_idle(40);
    check("divu_big", hilo, 64'h0000_0005_1999_9999);

    // MTHI/MTLO back-to-back
    busy_cycles = 0;
    offer(C_MTHI, 32'hA5A5_A5A5, 32'd0);
    offer(C_MTLO, 32'h5A5A_5A5A, 32'd0);
    check("mthi_mtlo", hilo, 64'hA5A5_A5A5_5A5A_5A5A);
    check("mt_no_busy", 64'(busy_cycles), 64'd0);

    // Flush in DIV cycle 10, with an MTHI offered in the flush cycle
    offer(C_DIV, 32'd100, 32'd7);
    for (int i = 0; i < 9; i++) step();
    flush = 1'b1; op_valid = 1'b1; op = C_MTHI; src_a = 32'h0000_FFFF;
    step();
    flush = 1'b0; op_valid = 1'b0; op = C_NONE;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hilo", hilo, 64'hA5A5_A5A5_5A5A_5A5A);
    offer(C_MTLO, 32'h0000_1234, 32'd0);
    check("post_flush_mtlo", hilo, 64'hA5A5_A5A5_0000_1234);

    // Flush during MUL
    offer(C_MULTU, 32'd9, 32'd9);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_mul_hilo", hilo, 64'hA5A5_A5A5_0000_1234);

    // Reset mid-DIV with an offer present
    offer(C_DIVU, 32'd1000, 32'd3);
    for (int i = 0; i < 5; i++) step();
    rst = 1'b0; op_valid = 1'b1; op = C_MTLO; src_a = 32'h0000_0099;
    step();
    rst = 1'b1; op_valid = 1'b0; op = C_NONE;
    check("rst_hilo", hilo, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    step();
    check("rst_idle", 64'(busy), 64'd0);

    // Multiply-accumulate encodings
    offer(C_MTLO, 32'd5, 32'd0);
    offer(C_MADDU, 32'd3, 32'd4);
    step();
    check("maddu", hilo, MADD_EN ? 64'd17 : 64'd5);
    offer(C_MSUB, 32'd2, 32'd3);
    step();
    check("msub", hilo, MADD_EN ? 64'd11 : 64'd5);

    // Undefined encoding ignored
    offer(4'd15, 32'd1, 32'd1);
    check("undef_busy", 64'(busy), 64'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
